// File: rtl/internal_defines.sv
// Definitions shared by the fetch stage and the decode control: FSM encoding
// and the bubble instruction that decodes as a no-write MOV r0,r0.
package internal_defines;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } if_state_t;

  localparam logic [31:0] NOP_ENCODING = 32'hE1A0_0000;
  localparam int unsigned MAX_FLUSH_CYCLES = 3;

  // Word-aligned branch target; the two low bits of the target are discarded.
  function automatic logic [29:0] target_word(input logic [31:0] target);
    return target[31:2];
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter with write enable and branch redirect. The PC is stored as a
// word index, so the two low address bits are zero by construction.
module if_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        pc_we,
  input  logic        redirect,
  input  logic [29:0] redirect_word,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_plus8
);

  localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

  logic [29:0] pc_word;

  // Redirect wins over the sequential increment.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc_word <= RESET_WORD;
    end else if (redirect) begin
      pc_word <= redirect_word;
    end else if (pc_we) begin
      pc_word <= pc_word + 30'd1;
    end
  end

  // Word arithmetic wraps modulo 2^30 words, i.e. modulo 2^32 bytes.
  assign pc       = {pc_word, 2'b00};
  assign pc_plus4 = {pc_word + 30'd1, 2'b00};
  assign pc_plus8 = {pc_word + 30'd2, 2'b00};

endmodule

// File: rtl/arm_if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address and loads the
// IF/ID register, inserting bubbles on boot, redirect flush and imem wait.
module arm_if_stage
  import internal_defines::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = NOP_ENCODING,
  parameter int unsigned FLUSH_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  input  logic        inst_ready,
  input  logic        real_PCWrite,
  input  logic        real_IFID_Write,
  input  logic        halted,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] IFID_inst,
  output logic [31:0] IFID_pc,
  output logic        IFID_valid,
  output logic [31:0] pc_plus8,
  output logic [31:0] fetch_count,
  output logic [1:0]  if_state
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  if_state_t   state, state_n;
  logic [1:0]  flush_cnt, flush_cnt_n;
  logic        pc_we, redirect;
  logic        ifid_we, ifid_bubble, count_inc;
  logic [31:0] pc, pc_plus4;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst_b         (rst_b),
    .pc_we         (pc_we),
    .redirect      (redirect),
    .redirect_word (target_word(br_target)),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_plus8      (pc_plus8)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= BOOT;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // Per-cycle priority: halt, redirect, flush countdown, stall, imem wait, fetch.
  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    pc_we       = 1'b0;
    redirect    = 1'b0;
    ifid_we     = 1'b0;
    ifid_bubble = 1'b0;
    count_inc   = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      HALT: state_n = HALT;
      default: begin
        if (halted) begin
          state_n = HALT;
        end else if (br_taken) begin
          // The instruction held in IF/ID is wrong-path, so overwrite it even under stall.
          redirect    = 1'b1;
          ifid_we     = 1'b1;
          ifid_bubble = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            flush_cnt_n = FLUSH_LOAD;
            state_n     = FLUSH;
          end else begin
            state_n = RUN;
          end
        end else if (state == FLUSH) begin
          ifid_we     = real_IFID_Write;
          ifid_bubble = 1'b1;
          flush_cnt_n = flush_cnt - 2'd1;
          if (flush_cnt <= 2'd1) state_n = RUN;
        end else if (!real_PCWrite || !real_IFID_Write) begin
          // A held PC re-issues the same fetch, so a permitted IF/ID write takes a bubble.
          pc_we       = real_PCWrite && inst_ready;
          ifid_we     = real_IFID_Write;
          ifid_bubble = 1'b1;
        end else if (!inst_ready) begin
          ifid_we     = 1'b1;
          ifid_bubble = 1'b1;
        end else begin
          pc_we     = 1'b1;
          ifid_we   = 1'b1;
          count_inc = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      IFID_inst   <= NOP_INST;
      IFID_pc     <= 32'h0000_0000;
      IFID_valid  <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else begin
      if (ifid_we) begin
        IFID_inst  <= ifid_bubble ? NOP_INST : inst;
        IFID_pc    <= pc;
        IFID_valid <= !ifid_bubble;
      end
      if (count_inc) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign inst_addr = pc;
  assign if_state  = state;

  // pc_plus4 is consumed inside the PC register; keep the tap for debug visibility.
  logic unused_tap;
  assign unused_tap = ^pc_plus4;

endmodule

// File: tb/tb_arm_if_stage.sv
// Directed bench for arm_if_stage with FLUSH_CYCLES=1 and RESET_PC=0.
module tb_arm_if_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        inst_ready;
  logic        real_PCWrite;
  logic        real_IFID_Write;
  logic        halted;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] IFID_inst;
  logic [31:0] IFID_pc;
  logic        IFID_valid;
  logic [31:0] pc_plus8;
  logic [31:0] fetch_count;
  logic [1:0]  if_state;

  int vectors = 0;
  int miscompares = 0;

  arm_if_stage #(
    .RESET_PC     (32'h0000_0000),
    .NOP_INST     (32'hE1A0_0000),
    .FLUSH_CYCLES (1)
  ) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .inst_addr       (inst_addr),
    .inst            (inst),
    .inst_ready      (inst_ready),
    .real_PCWrite    (real_PCWrite),
    .real_IFID_Write (real_IFID_Write),
    .halted          (halted),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .IFID_inst       (IFID_inst),
    .IFID_pc         (IFID_pc),
    .IFID_valid      (IFID_valid),
    .pc_plus8        (pc_plus8),
    .fetch_count     (fetch_count),
    .if_state        (if_state)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A reads as C0DE_<A[15:0]>.
  assign inst = {16'hC0DE, inst_addr[15:0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; inst_ready = 1'b1; real_PCWrite = 1'b1; real_IFID_Write = 1'b1;
    halted = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    tick(); tick();
    vectors++;
    if ({inst_addr, pc_plus8, if_state} !== {32'h0, 32'h8, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_pc addr=%h p8=%h st=%0d exp 0/8/0", inst_addr, pc_plus8, if_state);
    end
    vectors++;
    if ({IFID_inst, IFID_pc, IFID_valid, fetch_count} !== {NOP, 32'h0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_ifid inst=%h pc=%h v=%b cnt=%0d exp %h/0/0/0", IFID_inst, IFID_pc, IFID_valid, fetch_count, NOP);
    end
    rst_b = 1'b1;
  endtask

  task automatic test_run();
    tick();
    vectors++;
    if ({if_state, IFID_valid, inst_addr} !== {2'd1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL boot st=%0d v=%b addr=%h exp 1/0/0", if_state, IFID_valid, inst_addr);
    end
    tick();
    vectors++;
    if ({IFID_valid, IFID_pc, IFID_inst, inst_addr} !== {1'b1, 32'h0, 32'hC0DE_0000, 32'h4}) begin
      miscompares++;
      $display("FAIL run0 v=%b pc=%h inst=%h addr=%h exp 1/0/C0DE0000/4", IFID_valid, IFID_pc, IFID_inst, inst_addr);
    end
    tick();
    vectors++;
    if ({IFID_pc, IFID_inst} !== {32'h4, 32'hC0DE_0004}) begin
      miscompares++;
      $display("FAIL run4 pc=%h inst=%h exp 4/C0DE0004", IFID_pc, IFID_inst);
    end
    tick();
    vectors++;
    if ({IFID_pc, fetch_count, inst_addr, pc_plus8} !== {32'h8, 32'd3, 32'hC, 32'h14}) begin
      miscompares++;
      $display("FAIL run8 pc=%h cnt=%0d addr=%h p8=%h exp 8/3/C/14", IFID_pc, fetch_count, inst_addr, pc_plus8);
    end
  endtask

  task automatic test_stall();
    tick();
    vectors++;
    if ({IFID_pc, inst_addr, fetch_count} !== {32'hC, 32'h10, 32'd4}) begin
      miscompares++;
      $display("FAIL pre_stall pc=%h addr=%h cnt=%0d exp C/10/4", IFID_pc, inst_addr, fetch_count);
    end
    real_PCWrite = 1'b0; real_IFID_Write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({inst_addr, IFID_pc, IFID_inst, IFID_valid, fetch_count} !== {32'h10, 32'hC, 32'hC0DE_000C, 1'b1, 32'd4}) begin
        miscompares++;
        $display("FAIL stall_hold%0d addr=%h pc=%h inst=%h v=%b cnt=%0d exp 10/C/C0DE000C/1/4", i, inst_addr, IFID_pc, IFID_inst, IFID_valid, fetch_count);
      end
    end
    real_PCWrite = 1'b1; real_IFID_Write = 1'b1;
    tick();
    vectors++;
    if ({IFID_pc, IFID_inst, fetch_count, inst_addr} !== {32'h10, 32'hC0DE_0010, 32'd5, 32'h14}) begin
      miscompares++;
      $display("FAIL stall_resume pc=%h inst=%h cnt=%0d addr=%h exp 10/C0DE0010/5/14", IFID_pc, IFID_inst, fetch_count, inst_addr);
    end
    tick();
    vectors++;
    if ({IFID_pc, fetch_count} !== {32'h14, 32'd6}) begin
      miscompares++;
      $display("FAIL stall_next pc=%h cnt=%0d exp 14/6", IFID_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    real_PCWrite = 1'b0; real_IFID_Write = 1'b0;
    br_taken = 1'b1; br_target = 32'h0000_0103;
    tick();
    br_taken = 1'b0; real_PCWrite = 1'b1; real_IFID_Write = 1'b1;
    vectors++;
    if ({IFID_valid, IFID_inst, inst_addr, if_state} !== {1'b0, NOP, 32'h100, 2'd2}) begin
      miscompares++;
      $display("FAIL redirect v=%b inst=%h addr=%h st=%0d exp 0/E1A00000/100/2", IFID_valid, IFID_inst, inst_addr, if_state);
    end
    tick();
    vectors++;
    if ({IFID_valid, IFID_inst, inst_addr, if_state, fetch_count} !== {1'b0, NOP, 32'h100, 2'd1, 32'd6}) begin
      miscompares++;
      $display("FAIL flush v=%b inst=%h addr=%h st=%0d cnt=%0d exp 0/E1A00000/100/1/6", IFID_valid, IFID_inst, inst_addr, if_state, fetch_count);
    end
    tick();
    vectors++;
    if ({IFID_valid, IFID_pc, IFID_inst, fetch_count, inst_addr} !== {1'b1, 32'h100, 32'hC0DE_0100, 32'd7, 32'h104}) begin
      miscompares++;
      $display("FAIL target v=%b pc=%h inst=%h cnt=%0d addr=%h exp 1/100/C0DE0100/7/104", IFID_valid, IFID_pc, IFID_inst, fetch_count, inst_addr);
    end
  endtask

  task automatic test_wait_wrap();
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    tick();
    br_taken = 1'b0;
    vectors++;
    if ({inst_addr, pc_plus8, if_state} !== {32'hFFFF_FFFC, 32'h4, 2'd2}) begin
      miscompares++;
      $display("FAIL wrap_target addr=%h p8=%h st=%0d exp FFFFFFFC/4/2", inst_addr, pc_plus8, if_state);
    end
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({IFID_valid, IFID_inst, inst_addr, fetch_count} !== {1'b0, NOP, 32'hFFFF_FFFC, 32'd7}) begin
        miscompares++;
        $display("FAIL imem_wait%0d v=%b inst=%h addr=%h cnt=%0d exp 0/E1A00000/FFFFFFFC/7", i, IFID_valid, IFID_inst, inst_addr, fetch_count);
      end
    end
    inst_ready = 1'b1;
    tick();
    vectors++;
    if ({IFID_valid, IFID_pc, IFID_inst, inst_addr, pc_plus8, fetch_count} !==
        {1'b1, 32'hFFFF_FFFC, 32'hC0DE_FFFC, 32'h0, 32'h8, 32'd8}) begin
      miscompares++;
      $display("FAIL wrap v=%b pc=%h inst=%h addr=%h p8=%h cnt=%0d exp 1/FFFFFFFC/C0DEFFFC/0/8/8", IFID_valid, IFID_pc, IFID_inst, inst_addr, pc_plus8, fetch_count);
    end
  endtask

  task automatic test_halt();
    halted = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0200;
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({if_state, inst_addr, IFID_pc, IFID_inst, IFID_valid, fetch_count} !==
          {2'd3, 32'h0, 32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b1, 32'd8}) begin
        miscompares++;
        $display("FAIL halt%0d st=%0d addr=%h pc=%h inst=%h v=%b cnt=%0d exp 3/0/FFFFFFFC/C0DEFFFC/1/8", i, if_state, inst_addr, IFID_pc, IFID_inst, IFID_valid, fetch_count);
      end
      tick();
    end
    halted = 1'b0;
    tick();
    vectors++;
    if ({if_state, inst_addr, fetch_count} !== {2'd3, 32'h0, 32'd8}) begin
      miscompares++;
      $display("FAIL halt_sticky st=%0d addr=%h cnt=%0d exp 3/0/8", if_state, inst_addr, fetch_count);
    end
  endtask

  task automatic test_reset_mid_flush();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    tick(); tick();
    br_taken = 1'b1; br_target = 32'h0000_0040;
    tick();
    br_taken = 1'b0;
    vectors++;
    if ({if_state, inst_addr, fetch_count} !== {2'd2, 32'h40, 32'd1}) begin
      miscompares++;
      $display("FAIL pre_reset st=%0d addr=%h cnt=%0d exp 2/40/1", if_state, inst_addr, fetch_count);
    end
    #3;
    rst_b = 1'b0;
    #1;
    vectors++;
    if ({if_state, inst_addr, IFID_inst, IFID_pc, IFID_valid, fetch_count} !== {2'd0, 32'h0, NOP, 32'h0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL async_reset st=%0d addr=%h inst=%h pc=%h v=%b cnt=%0d exp 0/0/E1A00000/0/0/0", if_state, inst_addr, IFID_inst, IFID_pc, IFID_valid, fetch_count);
    end
    tick();
    vectors++;
    if ({if_state, inst_addr, fetch_count} !== {2'd0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_held st=%0d addr=%h cnt=%0d exp 0/0/0", if_state, inst_addr, fetch_count);
    end
    rst_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_wait_wrap();
    test_halt();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
